// File: rtl/iicmb_wb_regs.sv
`default_nettype none
// ============================================================================
// Module      : iicmb_wb_regs
// Description : Wishbone register front-end of the I2C multi-bus master.
//               Holds CSR/DPR/CMDR/FSMR, issues byte commands to the byte
//               FSM over valid/ready, handles Set Bus locally, drives irq_o.
// Revision    : 1.0 - initial release
// ============================================================================
module iicmb_wb_regs #(
    parameter int ADDR_WIDTH = 2,
    parameter int DATA_WIDTH = 8,
    parameter int NUM_BUSSES = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cyc_i,
    input  logic                  stb_i,
    input  logic                  we_i,
    input  logic [ADDR_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0] dat_i,
    output logic [DATA_WIDTH-1:0] dat_o,
    output logic                  ack_o,
    output logic                  irq_o,
    output logic                  cmd_valid_o,
    output logic [2:0]            cmd_o,
    output logic [7:0]            wr_data_o,
    output logic [3:0]            bus_id_o,
    input  logic                  cmd_ready_i,
    input  logic                  done_i,
    input  logic [1:0]            done_status_i,
    input  logic [7:0]            rd_data_i,
    input  logic                  rd_valid_i,
    input  logic                  bus_busy_i,
    input  logic                  bus_cap_i,
    input  logic [7:0]            fsm_state_i
);

    localparam logic [ADDR_WIDTH-1:0] c_ADR_CSR  = ADDR_WIDTH'(0);
    localparam logic [ADDR_WIDTH-1:0] c_ADR_DPR  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH-1:0] c_ADR_CMDR = ADDR_WIDTH'(2);
    localparam logic [2:0]            c_CMD_SETBUS = 3'b110;
    localparam logic [8:0]            c_NUM_BUSSES = 9'(NUM_BUSSES);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ISSUE  = 2'd1,
        S_WAIT   = 2'd2,
        S_SETBUS = 2'd3
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    logic                  r_ack;
    logic [DATA_WIDTH-1:0] r_dat;
    logic                  r_e;
    logic                  r_ie;
    logic [7:0]            r_wr_data;
    logic [7:0]            r_rd_data;
    logic [2:0]            r_cmd;
    logic [3:0]            r_bus_id;
    logic                  r_don;
    logic                  r_nak;
    logic                  r_al;
    logic                  r_err;
    logic                  r_irq_pend;
    logic                  r_irq;

    logic       w_acc;
    logic       w_wr;
    logic       w_rd;
    logic       w_csr_wr;
    logic       w_dpr_wr;
    logic       w_cmdr_wr;
    logic       w_cmdr_rd;
    logic       w_e_fall;
    logic       w_busy;
    logic       w_cmd_acc;
    logic       w_cmd_rej;
    logic       w_done;
    logic       w_setbus;
    logic       w_setbus_ok;
    logic       w_cmd_valid;
    logic [7:0] w_rdata;

    // A new access is accepted only while ack is low, so every access gets
    // exactly one ack pulse followed by at least one idle cycle.
    assign w_acc     = cyc_i & stb_i & ~r_ack;
    assign w_wr      = w_acc & we_i;
    assign w_rd      = w_acc & ~we_i;
    assign w_csr_wr  = w_wr & (adr_i == c_ADR_CSR);
    assign w_dpr_wr  = w_wr & (adr_i == c_ADR_DPR);
    assign w_cmdr_wr = w_wr & (adr_i == c_ADR_CMDR);
    assign w_cmdr_rd = w_rd & (adr_i == c_ADR_CMDR);
    assign w_e_fall  = w_csr_wr & r_e & ~dat_i[7];

    // Busy is judged on the state before any same-cycle completion, so a
    // CMDR write coinciding with done_i is still rejected.
    assign w_busy      = (r_state != S_IDLE);
    assign w_cmd_acc   = w_cmdr_wr & r_e & ~w_busy;
    assign w_cmd_rej   = w_cmdr_wr & r_e & w_busy;
    assign w_done      = done_i & (r_state == S_WAIT);
    assign w_setbus    = (r_state == S_SETBUS);
    assign w_setbus_ok = w_setbus & ({1'b0, r_wr_data} < c_NUM_BUSSES);

    // Command handshake state register.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic; disabling the core always returns to IDLE.
    always_comb begin
        w_state_nxt = r_state;
        w_cmd_valid = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (w_cmd_acc) begin
                    w_state_nxt = (dat_i[2:0] == c_CMD_SETBUS) ? S_SETBUS : S_ISSUE;
                end
            end
            S_ISSUE: begin
                w_cmd_valid = 1'b1;
                if (cmd_ready_i) begin
                    w_state_nxt = S_WAIT;
                end
            end
            S_WAIT: begin
                if (done_i) begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_SETBUS: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
        if (w_e_fall) begin
            w_state_nxt = S_IDLE;
            w_cmd_valid = (r_state == S_ISSUE);
        end
    end

    // Read-data multiplexer, sampled into dat_o at the accepting edge.
    always_comb begin
        w_rdata = 8'h00;
        case (adr_i)
            c_ADR_CSR:  w_rdata = {r_e, r_ie, bus_busy_i, bus_cap_i, r_bus_id};
            c_ADR_DPR:  w_rdata = r_rd_data;
            c_ADR_CMDR: w_rdata = {r_don, r_nak, r_al, r_err, 1'b0, r_cmd};
            default:    w_rdata = fsm_state_i;
        endcase
    end

    // Wishbone ack pulse and registered read data.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_ack <= 1'b0;
            r_dat <= '0;
        end else begin
            r_ack <= w_acc;
            if (w_rd) begin
                r_dat <= DATA_WIDTH'(w_rdata);
            end
        end
    end

    // Configuration and data registers; bus id and DPR survive a disable.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_e       <= 1'b0;
            r_ie      <= 1'b0;
            r_wr_data <= 8'h00;
            r_rd_data <= 8'h00;
            r_cmd     <= 3'd0;
            r_bus_id  <= 4'd0;
        end else begin
            if (w_csr_wr) begin
                r_e  <= dat_i[7];
                r_ie <= dat_i[6];
            end
            if (w_dpr_wr) begin
                r_wr_data <= dat_i[7:0];
            end
            if (rd_valid_i) begin
                r_rd_data <= rd_data_i;
            end
            if (w_cmd_acc) begin
                r_cmd <= dat_i[2:0];
            end
            if (w_setbus_ok) begin
                r_bus_id <= r_wr_data[3:0];
            end
        end
    end

    // Status bits and interrupt pending; later statements take priority,
    // so completions win over the clear caused by a CMDR read.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_don      <= 1'b0;
            r_nak      <= 1'b0;
            r_al       <= 1'b0;
            r_err      <= 1'b0;
            r_irq_pend <= 1'b0;
        end else if (w_e_fall) begin
            r_don      <= 1'b0;
            r_nak      <= 1'b0;
            r_al       <= 1'b0;
            r_err      <= 1'b0;
            r_irq_pend <= 1'b0;
        end else begin
            if (w_cmdr_rd) begin
                r_irq_pend <= 1'b0;
            end
            if (w_cmd_acc) begin
                r_don <= 1'b0;
                r_nak <= 1'b0;
                r_al  <= 1'b0;
                r_err <= 1'b0;
            end
            if (w_done) begin
                case (done_status_i)
                    2'd0:    r_don <= 1'b1;
                    2'd1:    r_nak <= 1'b1;
                    2'd2:    r_al  <= 1'b1;
                    default: r_err <= 1'b1;
                endcase
                r_irq_pend <= 1'b1;
            end
            if (w_cmd_rej) begin
                r_err      <= 1'b1;
                r_irq_pend <= 1'b1;
            end
            if (w_setbus) begin
                if (w_setbus_ok) begin
                    r_don <= 1'b1;
                end else begin
                    r_err <= 1'b1;
                end
                r_irq_pend <= 1'b1;
            end
        end
    end

    // Registered interrupt level.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_irq <= 1'b0;
        end else begin
            r_irq <= r_e & r_ie & r_irq_pend;
        end
    end

    assign dat_o       = r_dat;
    assign ack_o       = r_ack;
    assign irq_o       = r_irq;
    assign cmd_valid_o = w_cmd_valid & ~w_e_fall | (r_state == S_ISSUE) & ~w_e_fall;
    assign cmd_o       = r_cmd;
    assign wr_data_o   = r_wr_data;
    assign bus_id_o    = r_bus_id;

endmodule
`default_nettype wire

// File: tb/tb_iicmb_wb_regs.sv
`default_nettype none
// ============================================================================
// Module      : tb_iicmb_wb_regs
// Description : Scoreboard bench for iicmb_wb_regs with a transaction-level
//               register model and randomized WB / byte-FSM traffic.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_iicmb_wb_regs;

    localparam int c_NB = 16;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [1:0] adr = 2'd0;
    logic [7:0] dat_w = 8'h00;
    logic [7:0] dat_r;
    logic       ack, irq, cmd_valid;
    logic [2:0] cmd;
    logic [7:0] wr_data;
    logic [3:0] bus_id;
    logic       cmd_ready = 1'b0;
    logic       done = 1'b0;
    logic [1:0] done_st = 2'd0;
    logic [7:0] rd_data = 8'h00;
    logic       rd_valid = 1'b0;
    logic       bb = 1'b0, bc = 1'b0;
    logic [7:0] fsm_st = 8'h00;

    int checks = 0;
    int failures = 0;

    // Reference model: architectural register view of the core.
    bit         m_e, m_ie, m_pend, m_busy, m_wait;
    logic [3:0] m_bus;
    logic [7:0] m_dprw, m_rd;
    logic [2:0] m_cmd;
    logic [3:0] m_st;            // {DON, NAK, AL, ERR}

    logic [8:0]  acc_q[$];       // {is_read, expected read data}
    logic [10:0] cmd_q[$];       // {cmd, wr_data} expected at issue
    bit          cv_prev = 1'b0;
    bit          done_req = 1'b0;
    logic [1:0]  done_req_st = 2'd0;

    iicmb_wb_regs #(.ADDR_WIDTH(2), .DATA_WIDTH(8), .NUM_BUSSES(c_NB)) dut (
        .clk_i(clk), .rst_i(rst_n),
        .cyc_i(cyc), .stb_i(stb), .we_i(we), .adr_i(adr), .dat_i(dat_w),
        .dat_o(dat_r), .ack_o(ack), .irq_o(irq),
        .cmd_valid_o(cmd_valid), .cmd_o(cmd), .wr_data_o(wr_data), .bus_id_o(bus_id),
        .cmd_ready_i(cmd_ready), .done_i(done), .done_status_i(done_st),
        .rd_data_i(rd_data), .rd_valid_i(rd_valid),
        .bus_busy_i(bb), .bus_cap_i(bc), .fsm_state_i(fsm_st)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h t=%0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_e = 0; m_ie = 0; m_pend = 0; m_busy = 0; m_wait = 0;
        m_bus = 0; m_dprw = 0; m_rd = 0; m_cmd = 0; m_st = 0;
    endtask

    // Response monitor: every ack pops one scoreboard entry.
    initial forever begin
        @(negedge clk);
        if (rst_n && ack) begin
            if (acc_q.size() == 0) begin
                chk("unexpected_ack", 1, 0);
            end else begin
                logic [8:0] a;
                a = acc_q.pop_front();
                if (a[8]) chk("read_data", dat_r, a[7:0]);
            end
        end
    end

    // Command monitor: every rising cmd_valid_o pops one expected command.
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            cv_prev = 1'b0;
        end else begin
            if (cmd_valid && !cv_prev) begin
                if (cmd_q.size() == 0) begin
                    chk("unexpected_cmd_valid", 1, 0);
                end else begin
                    logic [10:0] e;
                    e = cmd_q.pop_front();
                    chk("cmd_issue", {cmd, wr_data}, e);
                end
            end
            cv_prev = cmd_valid;
        end
    end

    task automatic wb_cycle(input logic [1:0] a, input bit w, input logic [7:0] d,
                            input bit is_rd, input logic [7:0] exp);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = w; adr = a; dat_w = d;
        done = done_req; done_st = done_req_st;
        acc_q.push_back({is_rd, exp});
        @(posedge clk); #1;
        cyc = 0; stb = 0; we = 0; done = 0; done_req = 0;
        chk("ack_high", ack, 1);
        @(posedge clk); #1;
        chk("ack_single_pulse", ack, 0);
    endtask

    task automatic m_done(input logic [1:0] s);
        if (m_wait) begin
            m_st[3 - int'(s)] = 1'b1;
            m_pend = 1; m_busy = 0; m_wait = 0;
        end
    endtask

    task automatic csr_write(input logic [7:0] d);
        wb_cycle(2'd0, 1, d, 0, 8'h00);
        if (m_e && !d[7]) begin
            m_busy = 0; m_wait = 0; m_st = 0; m_pend = 0;
        end
        m_e = d[7]; m_ie = d[6];
    endtask

    task automatic dpr_write(input logic [7:0] d);
        wb_cycle(2'd1, 1, d, 0, 8'h00);
        m_dprw = d;
    endtask

    task automatic handshake(input int delay);
        repeat (delay) begin
            chk("valid_hold", cmd_valid, 1);
            @(posedge clk); #1;
        end
        chk("valid_before_ready", cmd_valid, 1);
        cmd_ready = 1;
        @(posedge clk); #1;
        cmd_ready = 0;
        chk("valid_drop_at_ready", cmd_valid, 0);
        m_wait = 1;
    endtask

    // delay < 0 leaves an accepted command waiting in ISSUE.
    task automatic cmdr_write(input logic [2:0] c, input int delay);
        bit issue;
        issue = 0;
        if (m_e) begin
            if (m_busy) begin
                m_st[0] = 1; m_pend = 1;
            end else begin
                m_st = 0; m_cmd = c;
                if (c == 3'b110) begin
                    if (m_dprw < c_NB) begin
                        m_bus = m_dprw[3:0]; m_st[3] = 1;
                    end else begin
                        m_st[0] = 1;
                    end
                    m_pend = 1;
                end else begin
                    m_busy = 1; issue = 1;
                    cmd_q.push_back({c, m_dprw});
                end
            end
        end
        wb_cycle(2'd2, 1, {5'($urandom), c}, 0, 8'h00);
        if (issue && delay >= 0) handshake(delay);
    endtask

    task automatic reg_read(input logic [1:0] a);
        logic [7:0] e;
        bb = 1'($urandom); bc = 1'($urandom); fsm_st = 8'($urandom);
        case (a)
            2'd0:    e = {m_e, m_ie, bb, bc, m_bus};
            2'd1:    e = m_rd;
            2'd2:    e = {m_st, 1'b0, m_cmd};
            default: e = fsm_st;
        endcase
        wb_cycle(a, 0, 8'($urandom), 1, e);
        if (a == 2'd2) m_pend = 0;
    endtask

    task automatic read_lit(input logic [1:0] a, input logic [7:0] exp);
        bb = 0; bc = 0;
        wb_cycle(a, 0, 8'h00, 1, exp);
        if (a == 2'd2) m_pend = 0;
    endtask

    task automatic pulse_done(input logic [1:0] s);
        @(posedge clk); #1;
        done = 1; done_st = s;
        @(posedge clk); #1;
        done = 0;
        m_done(s);
    endtask

    task automatic rd_load(input logic [7:0] v);
        @(posedge clk); #1;
        rd_data = v; rd_valid = 1;
        @(posedge clk); #1;
        rd_valid = 0;
        m_rd = v;
    endtask

    task automatic check_outs();
        @(posedge clk); #1;
        chk("irq", irq, m_e & m_ie & m_pend);
        chk("bus_id", bus_id, m_bus);
        chk("cmd_o", cmd, m_cmd);
        chk("wr_data", wr_data, m_dprw);
        chk("cmd_valid_idle", cmd_valid, 0);
    endtask

    initial begin
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ack", ack, 0);
        chk("rst_irq", irq, 0);
        chk("rst_cmd_valid", cmd_valid, 0);
        chk("rst_dat_o", dat_r, 0);
        rst_n = 1;
        check_outs();

        // Reset asserted while a command sits in ISSUE and an ack is high.
        csr_write(8'hC0);
        dpr_write(8'h03);
        cmdr_write(3'd6, 0);
        check_outs();
        cmdr_write(3'd1, -1);
        @(posedge clk); #1;
        cyc = 1; stb = 1; we = 0; adr = 2'd3;
        acc_q.push_back(9'h000);
        @(posedge clk); #1;
        cyc = 0; stb = 0;
        chk("pre_rst_ack", ack, 1);
        chk("pre_rst_valid", cmd_valid, 1);
        chk("pre_rst_irq", irq, 1);
        #1 rst_n = 0;
        #1;
        chk("async_rst_ack", ack, 0);
        chk("async_rst_valid", cmd_valid, 0);
        chk("async_rst_irq", irq, 0);
        acc_q.delete();
        cmd_q.delete();
        repeat (2) @(posedge clk);
        #1 rst_n = 1;
        model_reset();
        read_lit(2'd0, 8'h00);
        check_outs();

        // Set Bus, valid id.
        csr_write(8'hC0);
        dpr_write(8'h05);
        cmdr_write(3'd6, 0);
        check_outs();
        read_lit(2'd2, 8'h86);
        read_lit(2'd0, 8'hC5);
        check_outs();

        // Set Bus, id out of range.
        dpr_write(8'h20);
        cmdr_write(3'd6, 0);
        read_lit(2'd2, 8'h16);
        check_outs();

        // Normal command with delayed ready, NAK completion.
        cmdr_write(3'd1, 3);
        pulse_done(2'd1);
        check_outs();
        read_lit(2'd2, 8'h41);

        // Command rejected while waiting, then DON.
        cmdr_write(3'd4, 1);
        cmdr_write(3'd2, 0);
        read_lit(2'd2, 8'h14);
        check_outs();
        pulse_done(2'd0);
        read_lit(2'd2, 8'h94);

        // Interrupt enable gating and disable.
        csr_write(8'h80);
        cmdr_write(3'd1, 0);
        pulse_done(2'd2);
        check_outs();
        csr_write(8'hC0);
        check_outs();
        csr_write(8'h00);
        check_outs();
        csr_write(8'hC0);
        cmdr_write(3'd6, 0);
        check_outs();
        reg_read(2'd2);

        // done_i outside WAIT is ignored.
        pulse_done(2'd3);
        reg_read(2'd2);
        check_outs();

        // done_i together with a CMDR write, then with a CMDR read.
        cmdr_write(3'd3, 0);
        done_req = 1; done_req_st = 2'd2;
        cmdr_write(3'd5, 0);
        m_done(2'd2);
        check_outs();
        reg_read(2'd2);
        cmdr_write(3'd5, 2);
        done_req = 1; done_req_st = 2'd0;
        reg_read(2'd2);
        m_done(2'd0);
        check_outs();
        reg_read(2'd2);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            case ($urandom_range(0, 9))
                0: csr_write({($urandom_range(0, 7) != 0), 1'($urandom), 6'($urandom)});
                1: dpr_write(($urandom % 2) ? 8'($urandom_range(0, 15)) : 8'($urandom));
                2, 3: cmdr_write(3'($urandom), $urandom_range(0, 3));
                4, 5: reg_read(2'($urandom));
                6: pulse_done(2'($urandom));
                7: rd_load(8'($urandom));
                8: begin
                    if (m_wait) begin
                        logic [1:0] s;
                        s = 2'($urandom);
                        done_req = 1; done_req_st = s;
                        cmdr_write(3'($urandom), 0);
                        m_done(s);
                    end else begin
                        reg_read(2'd1);
                    end
                end
                default: begin
                    if (m_wait) begin
                        logic [1:0] s;
                        s = 2'($urandom);
                        done_req = 1; done_req_st = s;
                        reg_read(2'd2);
                        m_done(s);
                    end else begin
                        reg_read(2'd2);
                    end
                end
            endcase
            check_outs();
        end

        repeat (2) @(posedge clk);
        #1;
        chk("acc_queue_drained", acc_q.size(), 0);
        chk("cmd_queue_drained", cmd_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
